mac_pe: RTL

MAC_PE -- requirements
Module: mac_pe

---
 rtl/mac_pe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - three-stage signed fixed-point multiply-accumulate processing element
//
// Systolic MAC cell. The vector operand a_in is forwarded to the next PE one
// cycle later. The products a*b are summed into a wide wrapping accumulator.
// Each dot product is delimited by first/last beat flags.
//
// Optional feature: define MAC_PE_SAT_EN to clamp res to the DW-bit signed
// range and pulse sat. The accumulator itself keeps wrapping.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   in_valid, a_in, b_in             beat qualifier and signed operands
//   first, last, subtract            dot-product framing and add/subtract select
//   a_out, a_valid_out               registered a_in/in_valid for the next PE
//   res, res_valid, sat              result (held), one-cycle update pulse, clamp pulse
`timescale 1ns/1ps
module mac_pe #(
    parameter int DW   = 18,
    parameter int FRAC = 17,
    parameter int ACCW = 40
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic          first,
    input  logic          last,
    input  logic          subtract,
    output logic [DW-1:0] a_out,
    output logic          a_valid_out,
    output logic [DW-1:0] res,
    output logic          res_valid,
    output logic          sat
);

    localparam int PW = 2 * DW;

    if (ACCW < 2 * DW || ACCW < FRAC + DW) begin : g_param_check
        $error("mac_pe: ACCW must be >= 2*DW and >= FRAC+DW");
    end

    // Stage 1: operand and control capture, unconditional every cycle
    logic signed [DW-1:0] s1_a;
    logic signed [DW-1:0] s1_b;
    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic                 s1_sub;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sub   <= 1'b0;
        end else begin
            s1_a     <= a_in;
            s1_b     <= b_in;
            s1_valid <= in_valid;
            s1_first <= first;
            s1_last  <= last;
            s1_sub   <= subtract;
        end
    end

    assign a_out       = s1_a;
    assign a_valid_out = s1_valid;

    // Stage 2: full-precision signed product
    logic signed [PW-1:0] s2_prod;
    logic                 s2_valid;
    logic                 s2_first;
    logic                 s2_last;
    logic                 s2_sub;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_prod  <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sub   <= 1'b0;
        end else begin
            s2_prod  <= PW'(s1_a) * PW'(s1_b);
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_sub   <= s1_sub;
        end
    end

    // Stage 3: accumulate. The first flag restarts from zero, so a single
    // first+last beat yields just the (possibly negated) product.
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_base;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_next;
    logic        [DW-1:0]   res_slice;
    logic        [DW-1:0]   res_d;

    always_comb begin
        acc_base  = s2_first ? '0 : acc;
        prod_ext  = ACCW'(s2_prod);
        acc_next  = s2_sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
        res_slice = acc_next[FRAC+DW-1:FRAC];
    end

`ifdef MAC_PE_SAT_EN
    // The value fits in res only when every bit from the result MSB upward
    // is a copy of the sign.
    localparam int TW = ACCW - FRAC - DW + 1;
    logic [TW-1:0] top_bits;
    logic          ovf;
    logic          sat_q;

    always_comb begin
        top_bits = acc_next[ACCW-1:FRAC+DW-1];
        ovf      = !((&top_bits) || !(|top_bits));
        res_d    = res_slice;
        if (ovf) begin
            res_d = acc_next[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= s2_valid && s2_last && ovf;
        end
    end

    assign sat = sat_q;
`else
    assign res_d = res_slice;
    assign sat   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (s2_valid) begin
                acc <= acc_next;
                if (s2_last) begin
                    res       <= res_d;
                    res_valid <= 1'b1;
                end
            end
        end
    end

endmodule
